// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges the two write-back lanes of the dual-issue pipe into
// one in-order queue. The queue drains one entry per cycle into the single
// register-file write port. It also flags reads that hit a destination still
// waiting in the queue, so decode can stall on them.
module wb_port_arbiter #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_RegWrite0,
    input  logic               i_PCSrc0,
    input  logic [3:0]         i_WA3_0,
    input  logic [D_WIDTH-1:0] i_Result0,
    input  logic               i_RegWrite1,
    input  logic               i_PCSrc1,
    input  logic [3:0]         i_WA3_1,
    input  logic [D_WIDTH-1:0] i_Result1,
    input  logic [3:0]         i_RA1,
    input  logic [3:0]         i_RA2,
    output logic               o_Ready,
    output logic               o_RegWriteW,
    output logic               o_PCSrcW,
    output logic [3:0]         o_WA3W,
    output logic [D_WIDTH-1:0] o_ResultW,
    output logic               o_Pend1,
    output logic               o_Pend2,
    output logic [CW-1:0]      o_Count,
    output logic               o_Overflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    // Queue state
    logic [PW-1:0]      rdPtr;
    logic [PW-1:0]      wrPtr;
    logic [CW-1:0]      count;
    logic               overflow;

    // Entry storage, one field per array, indexed by slot
    logic [DEPTH-1:0]   entValid;
    logic [DEPTH-1:0]   entRegWrite;
    logic [DEPTH-1:0]   entPCSrc;
    logic [3:0]         entWA3    [DEPTH];
    logic [D_WIDTH-1:0] entResult [DEPTH];

    // Per-cycle control
    logic               laneValid0;
    logic               laneValid1;
    logic               ready;
    logic               push0;
    logic               push1;
    logic               pop;
    logic               dropAny;
    logic [CW-1:0]      pushCnt;
    logic [CW-1:0]      countNext;
    logic [PW-1:0]      slot0;
    logic [PW-1:0]      slot1;

    // Lane decode, push/pop decisions and next occupancy
    always_comb begin
        laneValid0 = i_RegWrite0 | i_PCSrc0;
        laneValid1 = i_RegWrite1 | i_PCSrc1;
        // Two free slots are guaranteed from the registered count alone, so
        // the retire happening in the same cycle never widens acceptance.
        ready      = (count <= CW'(DEPTH - 2));
        push0      = ready & laneValid0;
        push1      = ready & laneValid1;
        dropAny    = ~ready & (laneValid0 | laneValid1);
        pop        = (count != '0);
        pushCnt    = CW'(push0) + CW'(push1);
        countNext  = count + pushCnt - CW'(pop);
        // Lane1 packs behind lane0 only when lane0 actually took a slot.
        slot0      = wrPtr;
        slot1      = wrPtr + PW'(push0);
    end

    // Pointers, occupancy, sticky overflow and entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            entValid    <= '0;
            entRegWrite <= '0;
            entPCSrc    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entWA3[i]    <= '0;
                entResult[i] <= '0;
            end
        end else begin
            count <= countNext;
            rdPtr <= rdPtr + PW'(pop);
            wrPtr <= wrPtr + PW'(pushCnt);
            if (dropAny) begin
                overflow <= 1'b1;
            end
            // Head and push slots never coincide: a push needs two free
            // slots, and when empty nothing retires.
            if (pop) begin
                entValid[rdPtr] <= 1'b0;
            end
            if (push0) begin
                entValid[slot0]    <= 1'b1;
                entRegWrite[slot0] <= i_RegWrite0;
                entPCSrc[slot0]    <= i_PCSrc0;
                entWA3[slot0]      <= i_WA3_0;
                entResult[slot0]   <= i_Result0;
            end
            if (push1) begin
                entValid[slot1]    <= 1'b1;
                entRegWrite[slot1] <= i_RegWrite1;
                entPCSrc[slot1]    <= i_PCSrc1;
                entWA3[slot1]      <= i_WA3_1;
                entResult[slot1]   <= i_Result1;
            end
        end
    end

    // Head entry drives the write port directly; all zero while empty
    always_comb begin
        o_RegWriteW = 1'b0;
        o_PCSrcW    = 1'b0;
        o_WA3W      = '0;
        o_ResultW   = '0;
        if (pop) begin
            o_RegWriteW = entRegWrite[rdPtr];
            o_PCSrcW    = entPCSrc[rdPtr];
            o_WA3W      = entWA3[rdPtr];
            o_ResultW   = entResult[rdPtr];
        end
    end

    // Pending-write lookup over every queued entry, head included
    always_comb begin
        o_Pend1 = 1'b0;
        o_Pend2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entValid[i] && entRegWrite[i] && (entWA3[i] == i_RA1)) begin
                o_Pend1 = 1'b1;
            end
            if (entValid[i] && entRegWrite[i] && (entWA3[i] == i_RA2)) begin
                o_Pend2 = 1'b1;
            end
        end
    end

    // Status outputs
    always_comb begin
        o_Ready    = ready;
        o_Count    = count;
        o_Overflow = overflow;
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scenario tasks against a queue-based scoreboard of the
// write-back queue. Inputs change and outputs are sampled on the falling edge.
module tb_wb_port_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef logic [DW+5:0] ent_t;  // {RegWrite, PCSrc, WA3, Result}

    logic          clk;
    logic          rst;
    logic          i_RegWrite0, i_PCSrc0, i_RegWrite1, i_PCSrc1;
    logic [3:0]    i_WA3_0, i_WA3_1, i_RA1, i_RA2;
    logic [DW-1:0] i_Result0, i_Result1;
    logic          o_Ready, o_RegWriteW, o_PCSrcW, o_Pend1, o_Pend2, o_Overflow;
    logic [3:0]    o_WA3W;
    logic [DW-1:0] o_ResultW;
    logic [CW-1:0] o_Count;

    ent_t sbQ[$];
    bit   expOverflow;
    int   nTests;
    int   nFail;
    ent_t obs;
    ent_t expHead;

    wb_port_arbiter #(.D_WIDTH(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .i_RegWrite0(i_RegWrite0), .i_PCSrc0(i_PCSrc0), .i_WA3_0(i_WA3_0), .i_Result0(i_Result0),
        .i_RegWrite1(i_RegWrite1), .i_PCSrc1(i_PCSrc1), .i_WA3_1(i_WA3_1), .i_Result1(i_Result1),
        .i_RA1(i_RA1), .i_RA2(i_RA2),
        .o_Ready(o_Ready), .o_RegWriteW(o_RegWriteW), .o_PCSrcW(o_PCSrcW), .o_WA3W(o_WA3W),
        .o_ResultW(o_ResultW), .o_Pend1(o_Pend1), .o_Pend2(o_Pend2), .o_Count(o_Count),
        .o_Overflow(o_Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {o_RegWriteW, o_PCSrcW, o_WA3W, o_ResultW};

    // Expected pending flag: any queued entry that writes register ra
    function automatic bit modelPend(input logic [3:0] ra);
        bit p = 1'b0;
        foreach (sbQ[i]) begin
            if (sbQ[i][DW+5] && (sbQ[i][DW+3:DW] == ra)) p = 1'b1;
        end
        return p;
    endfunction

    function automatic bit modelReady();
        return (DEPTH - sbQ.size()) >= 2;
    endfunction

    function automatic ent_t modelHead();
        return (sbQ.size() > 0) ? sbQ[0] : '0;
    endfunction

    // One clock of stimulus: retire the model head, drive lanes, push accepted lanes
    task automatic drive(input logic rw0, input logic pc0, input logic [3:0] wa0, input logic [DW-1:0] r0,
                         input logic rw1, input logic pc1, input logic [3:0] wa1, input logic [DW-1:0] r1);
        bit rdy = modelReady();
        if (sbQ.size() > 0) void'(sbQ.pop_front());
        i_RegWrite0 = rw0; i_PCSrc0 = pc0; i_WA3_0 = wa0; i_Result0 = r0;
        i_RegWrite1 = rw1; i_PCSrc1 = pc1; i_WA3_1 = wa1; i_Result1 = r1;
        if (rw0 | pc0) begin
            if (rdy) sbQ.push_back({rw0, pc0, wa0, r0});
            else expOverflow = 1'b1;
        end
        if (rw1 | pc1) begin
            if (rdy) sbQ.push_back({rw1, pc1, wa1, r1});
            else expOverflow = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, '0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sbQ.delete();
        expOverflow = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nTests++; if (o_Ready !== 1'b1) begin nFail++; $display("FAIL reset_ready: got %b want 1", o_Ready); end
        nTests++; if (o_Count !== 3'd0) begin nFail++; $display("FAIL reset_count: got %0d want 0", o_Count); end
        nTests++; if (obs !== '0) begin nFail++; $display("FAIL reset_wport: got %h want 0", obs); end
        nTests++; if ({o_Overflow, o_Pend1, o_Pend2} !== 3'b000) begin nFail++; $display("FAIL reset_flags: got %b want 000", {o_Overflow, o_Pend1, o_Pend2}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dual_push();
        drive(1'b1, 1'b0, 4'd3, 32'h11, 1'b1, 1'b0, 4'd5, 32'h22);
        for (int c = 0; c < 3; c++) begin
            expHead = modelHead();
            nTests++; if (obs !== expHead) begin nFail++; $display("FAIL dual_wport c%0d: got %h want %h", c, obs, expHead); end
            nTests++; if (o_Count !== CW'(sbQ.size())) begin nFail++; $display("FAIL dual_count c%0d: got %0d want %0d", c, o_Count, sbQ.size()); end
            idle();
        end
    endtask

    task automatic test_same_dest();
        i_RA1 = 4'd7;
        i_RA2 = 4'd2;
        drive(1'b1, 1'b0, 4'd7, 32'hA, 1'b1, 1'b0, 4'd7, 32'hB);
        for (int c = 0; c < 3; c++) begin
            expHead = modelHead();
            nTests++; if (obs !== expHead) begin nFail++; $display("FAIL samedest_wport c%0d: got %h want %h", c, obs, expHead); end
            nTests++; if (o_Pend1 !== modelPend(i_RA1)) begin nFail++; $display("FAIL samedest_pend1 c%0d: got %b want %b", c, o_Pend1, modelPend(i_RA1)); end
            nTests++; if (o_Pend2 !== modelPend(i_RA2)) begin nFail++; $display("FAIL samedest_pend2 c%0d: got %b want %b", c, o_Pend2, modelPend(i_RA2)); end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d = 32'h100;
        bit   rdySeq[3] = '{1'b1, 1'b1, 1'b0};
        int   cntSeq[3] = '{0, 2, 3};
        for (int c = 0; c < 18; c++) begin
            expHead = modelHead();
            if (c < 3) begin
                nTests++; if (o_Ready !== rdySeq[c]) begin nFail++; $display("FAIL b2b_readyseq c%0d: got %b want %b", c, o_Ready, rdySeq[c]); end
                nTests++; if (o_Count !== CW'(cntSeq[c])) begin nFail++; $display("FAIL b2b_countseq c%0d: got %0d want %0d", c, o_Count, cntSeq[c]); end
            end
            nTests++; if (o_Ready !== modelReady()) begin nFail++; $display("FAIL b2b_ready c%0d: got %b want %b", c, o_Ready, modelReady()); end
            nTests++; if (o_Count !== CW'(sbQ.size())) begin nFail++; $display("FAIL b2b_count c%0d: got %0d want %0d", c, o_Count, sbQ.size()); end
            nTests++; if (obs !== expHead) begin nFail++; $display("FAIL b2b_wport c%0d: got %h want %h", c, obs, expHead); end
            if (c < 13 && modelReady()) begin
                drive(1'b1, 1'b0, 4'(c), d, 1'b1, 1'b0, 4'(c + 8), d + 1);
                d = d + 2;
            end else begin
                idle();
            end
        end
        nTests++; if (o_Overflow !== 1'b0) begin nFail++; $display("FAIL b2b_overflow: got %b want 0", o_Overflow); end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 10; c++) begin
            expHead = modelHead();
            nTests++; if (obs !== expHead) begin nFail++; $display("FAIL ovf_wport c%0d: got %h want %h", c, obs, expHead); end
            nTests++; if (o_Overflow !== expOverflow) begin nFail++; $display("FAIL ovf_flag c%0d: got %b want %b", c, o_Overflow, expOverflow); end
            if (c < 4) drive(1'b1, 1'b0, 4'd1, 32'h200 + c, 1'b1, 1'b0, 4'd2, 32'h300 + c);
            else idle();
        end
        nTests++; if (o_Overflow !== 1'b1) begin nFail++; $display("FAIL ovf_sticky: got %b want 1", o_Overflow); end
        applyReset();
        nTests++; if (o_Overflow !== 1'b0) begin nFail++; $display("FAIL ovf_cleared: got %b want 0", o_Overflow); end
    endtask

    task automatic test_pcsrc_reset();
        i_RA1 = 4'd9;
        i_RA2 = 4'd9;
        drive(1'b0, 1'b1, 4'd9, 32'h55, 1'b0, 1'b0, 4'd0, '0);
        for (int c = 0; c < 2; c++) begin
            expHead = modelHead();
            nTests++; if (obs !== expHead) begin nFail++; $display("FAIL pc_wport c%0d: got %h want %h", c, obs, expHead); end
            nTests++; if ({o_Pend1, o_Pend2} !== 2'b00) begin nFail++; $display("FAIL pc_pend c%0d: got %b want 00", c, {o_Pend1, o_Pend2}); end
            idle();
        end
        drive(1'b1, 1'b0, 4'd4, 32'h61, 1'b1, 1'b0, 4'd6, 32'h62);
        drive(1'b1, 1'b0, 4'd9, 32'h63, 1'b1, 1'b0, 4'd10, 32'h64);
        nTests++; if (o_Count !== 3'd3) begin nFail++; $display("FAIL midrst_precount: got %0d want 3", o_Count); end
        nTests++; if (o_Pend1 !== 1'b1) begin nFail++; $display("FAIL midrst_prepend: got %b want 1", o_Pend1); end
        idle();
        #2;
        rst = 1'b1;
        #1;
        nTests++; if (o_Count !== 3'd0) begin nFail++; $display("FAIL midrst_count: got %0d want 0", o_Count); end
        nTests++; if (obs !== '0) begin nFail++; $display("FAIL midrst_wport: got %h want 0", obs); end
        nTests++; if (o_Ready !== 1'b1) begin nFail++; $display("FAIL midrst_ready: got %b want 1", o_Ready); end
        @(negedge clk);
        rst = 1'b0;
        sbQ.delete();
        @(negedge clk);
        nTests++; if (o_Count !== 3'd0) begin nFail++; $display("FAIL postrst_count: got %0d want 0", o_Count); end
        nTests++; if ({obs, o_Pend1} !== '0) begin nFail++; $display("FAIL postrst_outs: got %h want 0", {obs, o_Pend1}); end
    endtask

    initial begin
        nTests = 0;
        nFail = 0;
        expOverflow = 1'b0;
        rst = 1'b1;
        i_RegWrite0 = 1'b0; i_PCSrc0 = 1'b0; i_WA3_0 = '0; i_Result0 = '0;
        i_RegWrite1 = 1'b0; i_PCSrc1 = 1'b0; i_WA3_1 = '0; i_Result1 = '0;
        i_RA1 = '0; i_RA2 = '0;
        test_reset();
        test_dual_push();
        test_same_dest();
        test_back_to_back();
        test_overflow();
        test_pcsrc_reset();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
